// File: rtl/fnd_pkg.sv
// Shared definitions for the FND scan controller slice.
// Holds the controller FSM encoding, value limits and the small
// arithmetic helpers used by the binary-to-BCD converter.
package fnd_pkg;

    localparam int DATA_W     = 14;
    localparam int BCD_W      = 16;
    localparam int NUM_DIGITS = 4;

    localparam logic [DATA_W-1:0] MAX_VALUE = 14'd9999;

    // Iteration counter start value: one shift-add step per input bit.
    localparam logic [3:0] LAST_ITER = 4'd13;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    // Values above the 4-digit range saturate to 9999.
    function automatic logic [DATA_W-1:0] clamp_value(input logic [DATA_W-1:0] v);
        return (v > MAX_VALUE) ? MAX_VALUE : v;
    endfunction

    // Double-dabble correction: a nibble of 5 or more gets +3 so the
    // following shift carries correctly into the next decimal digit.
    function automatic logic [3:0] dabble(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/fnd_scan_controller_if.sv
// Bus between the application logic and the FND scan controller.
//   i_valid/o_ready/i_data : value handshake (application -> controller)
//   o_overflow             : sticky "value exceeded 9999" flag
//   o_digitSelect/o_value/o_en : drive to the digit-select and font decoders
// master = application side, slave = controller side.
interface fnd_scan_controller_if;
    import fnd_pkg::*;

    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_data;
    logic              o_overflow;
    logic [1:0]        o_digitSelect;
    logic [3:0]        o_value;
    logic              o_en;

    modport master (
        output i_valid, i_data,
        input  o_ready, o_overflow, o_digitSelect, o_value, o_en
    );

    modport slave (
        input  i_valid, i_data,
        output o_ready, o_overflow, o_digitSelect, o_value, o_en
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (double-dabble),
// one shift-add step per clock, 14 steps per conversion.
//   clk, reset_n : clock and synchronous active-low reset
//   start        : load bin_in and begin a conversion
//   bin_in       : binary value, must already be limited to 9999
//   done         : high during the final step of a conversion
//   bcd_out      : BCD result, valid the cycle after done
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] bin_in,
    output logic              done,
    output logic [BCD_W-1:0]  bcd_out
);

    logic              busy;
    logic [3:0]        iter;
    logic [DATA_W-1:0] bin_sr;
    logic [BCD_W-1:0]  bcd_sr;
    logic [BCD_W-1:0]  bcd_adj;

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            bcd_adj[4*i +: 4] = dabble(bcd_sr[4*i +: 4]);
        end
    end

    // Corrected BCD and the binary register shift left as one chain,
    // pulling the binary MSB into the BCD LSB.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy   <= 1'b0;
            iter   <= 4'd0;
            bin_sr <= '0;
            bcd_sr <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            iter   <= LAST_ITER;
            bin_sr <= bin_in;
            bcd_sr <= '0;
        end else if (busy) begin
            bcd_sr <= {bcd_adj[BCD_W-2:0], bin_sr[DATA_W-1]};
            bin_sr <= {bin_sr[DATA_W-2:0], 1'b0};
            if (iter == 4'd0) begin
                busy <= 1'b0;
            end else begin
                iter <= iter - 4'd1;
            end
        end
    end

    assign done    = busy && (iter == 4'd0);
    assign bcd_out = bcd_sr;

endmodule

// File: rtl/fnd_scan_controller.sv
// Sequencer for a 4-digit FND display. Accepts a binary value over a
// valid/ready handshake, converts it to BCD, and time-multiplexes the
// digits into the digit-select and font decoders.
//   i_clk     : system clock, rising edge
//   i_reset_n : synchronous active-low reset
//   bus       : handshake, overflow flag and decoder drive (slave side)
// Parameters: SCAN_DIV clocks per digit slot (2..2^20);
//             BLANK_LZ != 0 blanks leading zeros (digit 0 always shown).
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int BLANK_LZ = 1
)
(
    input  logic i_clk,
    input  logic i_reset_n,
    fnd_scan_controller_if.slave bus
);

    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0]    pre_cnt;
    logic             tick;
    logic             tick_d;
    logic [1:0]       digit;
    logic [BCD_W-1:0] disp;
    logic [1:0]       state;
    logic             overflow;
    logic             transfer;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;
    logic [3:0]       nibble;
    logic             show;
    logic [1:0]       dsel_q;
    logic [3:0]       value_q;
    logic             en_q;

    assign tick     = (pre_cnt == PW'(SCAN_DIV - 1));
    assign transfer = bus.i_valid && (state == IDLE);

    bin2bcd_seq u_bin2bcd (
        .clk     (i_clk),
        .reset_n (i_reset_n),
        .start   (transfer),
        .bin_in  (clamp_value(bus.i_data)),
        .done    (conv_done),
        .bcd_out (conv_bcd)
    );

    // Prescaler and digit counter. tick_d marks the cycle after the
    // digit counter moved, which is when the output registers refresh.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            pre_cnt <= '0;
            digit   <= 2'd0;
            tick_d  <= 1'b0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            tick_d  <= tick;
            if (tick) begin
                digit <= digit + 2'd1;
            end
        end
    end

    // Handshake FSM. The display register only changes in DONE, so the
    // previous value keeps scanning for the whole conversion.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            overflow <= 1'b0;
            disp     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        state <= CONVERT;
                        if (bus.i_data > MAX_VALUE) begin
                            overflow <= 1'b1;
                        end
                    end
                end
                CONVERT: begin
                    if (conv_done) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    disp  <= conv_bcd;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A digit is blanked when it and every higher digit are zero.
    assign nibble = disp[{digit, 2'b00} +: 4];
    assign show   = (BLANK_LZ == 0) || (digit == 2'd0) ||
                    ((disp >> {digit, 2'b00}) != '0);

    // Outputs hold their reset values (enable off) until the first slot ends.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            dsel_q  <= 2'd0;
            value_q <= 4'd0;
            en_q    <= 1'b0;
        end else if (tick_d) begin
            dsel_q  <= digit;
            value_q <= nibble;
            en_q    <= show;
        end
    end

    assign bus.o_ready       = (state == IDLE);
    assign bus.o_overflow    = overflow;
    assign bus.o_digitSelect = dsel_q;
    assign bus.o_value       = value_q;
    assign bus.o_en          = en_q;

endmodule
